alu_arbiter_seq: RTL and testbench



---
 rtl/alu_arbiter_seq.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_seq.sv
// alu_arbiter_seq: round-robin sequencer that shares one registered-latency 8-bit ALU
// between two valid/ready requesters and returns each result on the originator's channel.
module alu_arbiter_seq #(
  parameter int ALU_LAT = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ0_VALID,
  input  logic       REQ1_VALID,
  output logic       REQ0_READY,
  output logic       REQ1_READY,
  input  logic [3:0] REQ0_OP,
  input  logic [3:0] REQ1_OP,
  input  logic [7:0] REQ0_A,
  input  logic [7:0] REQ1_A,
  input  logic [7:0] REQ0_B,
  input  logic [7:0] REQ1_B,
  output logic       RSP0_VALID,
  output logic       RSP1_VALID,
  input  logic       RSP0_READY,
  input  logic       RSP1_READY,
  output logic [7:0] RSP_F,
  output logic [5:0] RSP_FLAGS,
  output logic       ALU_S2,
  output logic       ALU_S1,
  output logic [1:0] ALU_SEL,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  input  logic [7:0] ALU_F,
  input  logic [5:0] ALU_FLAGS,
  output logic       BUSY,
  output logic [1:0] DBG_STATE
);

  // Handshakes: a transfer happens on the rising CLK edge where VALID and READY are both
  // high; a requester may drop VALID before acceptance, and READY never waits on RSP_READY.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic       r_last;
  logic       r_owner;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_f;
  logic [5:0] r_flags;

  logic w_idle;
  logic w_grant;
  logic w_acc0;
  logic w_acc1;
  logic w_accept;
  logic w_cnt_zero;
  logic w_rsp_hs;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_grant = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      w_grant = ~r_last;
    end else if (REQ1_VALID) begin
      w_grant = 1'b1;
    end
  end

  assign w_idle     = (r_state == S_IDLE) && RST_N;
  assign w_acc0     = w_idle && REQ0_VALID && !w_grant;
  assign w_acc1     = w_idle && REQ1_VALID && w_grant;
  assign w_accept   = w_acc0 | w_acc1;
  assign w_cnt_zero = (r_cnt == 3'd0);
  assign w_rsp_hs   = (r_state == S_RESP) && (r_owner ? RSP1_READY : RSP0_READY);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next_state = S_EXEC;
      S_EXEC:  if (w_cnt_zero) w_next_state = S_RESP;
      S_RESP:  if (w_rsp_hs)   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= 3'd0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_op    <= 4'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_f     <= 8'd0;
      r_flags <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner <= w_acc1;
            r_op    <= w_acc1 ? REQ1_OP : REQ0_OP;
            r_a     <= w_acc1 ? REQ1_A  : REQ0_A;
            r_b     <= w_acc1 ? REQ1_B  : REQ0_B;
            r_cnt   <= 3'(ALU_LAT);
          end
        end
        S_EXEC: begin
          // Count down the ALU latency, then sample its result on the final edge.
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_f     <= ALU_F;
            r_flags <= ALU_FLAGS;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) r_last <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign REQ0_READY = w_acc0;
  assign REQ1_READY = w_acc1;
  assign RSP0_VALID = (r_state == S_RESP) && !r_owner;
  assign RSP1_VALID = (r_state == S_RESP) && r_owner;
  assign RSP_F      = r_f;
  assign RSP_FLAGS  = r_flags;
  assign ALU_S2     = r_op[3];
  assign ALU_S1     = r_op[2];
  assign ALU_SEL    = r_op[1:0];
  assign ALU_A      = r_a;
  assign ALU_B      = r_b;
  assign BUSY       = (r_state != S_IDLE);
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: three instances (ALU_LAT 0, 1, 3), each with its own
// delayed ALU model, checked cycle by cycle against a transaction-level reference.
module tb_alu_arbiter_seq;

  logic clk;
  logic rst_n;

  logic [2:0]      req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [2:0]      req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_s2, alu_s1;
  logic [2:0][3:0] req0_op, req1_op;
  logic [2:0][7:0] req0_a, req0_b, req1_a, req1_b, rsp_f, alu_a, alu_b, alu_f;
  logic [2:0][5:0] rsp_flags, alu_flags;
  logic [2:0][1:0] alu_sel, dbg_state;

  int n_vec;
  int n_err;

  // Reference state for the instance under test.
  int          m_lat;
  int          m_owner;
  int          m_last;
  int          m_age;
  bit          m_busy;
  logic [13:0] m_res;
  logic [19:0] m_alu;
  logic [14:0] exp_q[$];
  int          grant_log[$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  // Stand-in ALU: {over_flow, carry_out, flag_zero, A_equal_B, B_bigger, A_bigger, F}.
  function automatic logic [13:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] f;
    logic       ov;
    s  = '0;
    ov = 1'b0;
    case (op[1:0])
      2'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[7] == b[7]) && (s[7] != a[7]);
      end
      2'd1: begin
        s  = {1'b0, a} - {1'b0, b};
        ov = (a[7] != b[7]) && (s[7] != a[7]);
      end
      2'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    f = s[7:0];
    if (op[2]) f = ~f;
    if (op[3]) f = {f[3:0], f[7:4]};
    return {ov, s[8], (f == 8'd0), (a == b), (b > a), (a > b), f};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    logic [13:0] w_now;
    logic [13:0] pipe [8];

    assign w_now = alu_model({alu_s2[g], alu_s1[g], alu_sel[g]}, alu_a[g], alu_b[g]);

    always_ff @(posedge clk) begin
      pipe[0] <= w_now;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    if (LAT == 0) begin : g_comb
      assign {alu_flags[g], alu_f[g]} = w_now;
    end else begin : g_reg
      assign {alu_flags[g], alu_f[g]} = pipe[LAT-1];
    end

    alu_arbiter_seq #(.ALU_LAT(LAT)) u_dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .REQ0_VALID(req0_valid[g]),
      .REQ1_VALID(req1_valid[g]),
      .REQ0_READY(req0_ready[g]),
      .REQ1_READY(req1_ready[g]),
      .REQ0_OP   (req0_op[g]),
      .REQ1_OP   (req1_op[g]),
      .REQ0_A    (req0_a[g]),
      .REQ1_A    (req1_a[g]),
      .REQ0_B    (req0_b[g]),
      .REQ1_B    (req1_b[g]),
      .RSP0_VALID(rsp0_valid[g]),
      .RSP1_VALID(rsp1_valid[g]),
      .RSP0_READY(rsp0_ready[g]),
      .RSP1_READY(rsp1_ready[g]),
      .RSP_F     (rsp_f[g]),
      .RSP_FLAGS (rsp_flags[g]),
      .ALU_S2    (alu_s2[g]),
      .ALU_S1    (alu_s1[g]),
      .ALU_SEL   (alu_sel[g]),
      .ALU_A     (alu_a[g]),
      .ALU_B     (alu_b[g]),
      .ALU_F     (alu_f[g]),
      .ALU_FLAGS (alu_flags[g]),
      .BUSY      (busy[g]),
      .DBG_STATE (dbg_state[g])
    );
  end

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp_v);
    end
  endtask

  // Drivers
  task automatic clear_inputs();
    req0_valid = '0; req1_valid = '0; rsp0_ready = '0; rsp1_ready = '0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic set_req(input int k, input int r, input logic v, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (r == 0) begin
      req0_valid[k] = v; req0_op[k] = op; req0_a[k] = a; req0_b[k] = b;
    end else begin
      req1_valid[k] = v; req1_op[k] = op; req1_a[k] = a; req1_b[k] = b;
    end
  endtask

  task automatic model_reset(input int k);
    m_lat = lat_of(k); m_owner = 0; m_last = 1; m_age = 0; m_busy = 0;
    m_res = '0; m_alu = '0;
    exp_q.delete();
    grant_log.delete();
  endtask

  task automatic check_reset_vals(input int k);
    check_eq("rst_req_ready", {req1_ready[k], req0_ready[k]}, 0);
    check_eq("rst_rsp_valid", {rsp1_valid[k], rsp0_valid[k]}, 0);
    check_eq("rst_busy", busy[k], 0);
    check_eq("rst_rsp_res", {rsp_flags[k], rsp_f[k]}, 0);
    check_eq("rst_alu_lines", {alu_s2[k], alu_s1[k], alu_sel[k], alu_a[k], alu_b[k]}, 0);
  endtask

  // Called at a negedge with this cycle's inputs already applied; returns at the next negedge.
  task automatic cycle(input int k);
    logic        e0, e1, rv, hs;
    logic [14:0] act;
    logic [14:0] exp_e;
    logic [19:0] req_w;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_busy) begin
      if (req0_valid[k] && req1_valid[k]) begin
        if (m_last == 1) e0 = 1'b1; else e1 = 1'b1;
      end else if (req0_valid[k]) begin
        e0 = 1'b1;
      end else if (req1_valid[k]) begin
        e1 = 1'b1;
      end
    end
    rv = m_busy && (m_age >= m_lat + 1);
    hs = rv && ((m_owner == 1) ? rsp1_ready[k] : rsp0_ready[k]);
    check_eq("req_ready", {req1_ready[k], req0_ready[k]}, {e1, e0});
    check_eq("rsp_valid", {rsp1_valid[k], rsp0_valid[k]},
             rv ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00);
    check_eq("busy", busy[k], m_busy);
    check_eq("rsp_res", {rsp_flags[k], rsp_f[k]}, m_res);
    check_eq("alu_lines", {alu_s2[k], alu_s1[k], alu_sel[k], alu_a[k], alu_b[k]}, m_alu);
    act   = {rsp1_valid[k], rsp_flags[k], rsp_f[k]};
    req_w = e1 ? {req1_op[k], req1_a[k], req1_b[k]} : {req0_op[k], req0_a[k], req0_b[k]};
    @(posedge clk);
    if (hs) begin
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check_eq("scoreboard", act, exp_e);
      end
      m_busy = 0;
      m_last = m_owner;
    end else if (m_busy) begin
      if (m_age < m_lat + 1) begin
        m_age++;
        if (m_age == m_lat + 1) m_res = exp_q[0][13:0];
      end
    end else if (e0 || e1) begin
      m_owner = e1 ? 1 : 0;
      m_busy  = 1;
      m_age   = 0;
      m_alu   = req_w;
      exp_q.push_back({e1, alu_model(req_w[19:16], req_w[15:8], req_w[7:0])});
      grant_log.push_back(m_owner);
    end
    @(negedge clk);
  endtask

  task automatic run(input int k, input int n);
    for (int i = 0; i < n; i++) cycle(k);
  endtask

  task automatic do_reset(input int k);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check_reset_vals(k);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(k);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1);

    // Single operation on requester 0
    rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b1;
    set_req(1, 0, 1'b1, 4'b0000, 8'hFF, 8'hAA);
    cycle(1);
    set_req(1, 0, 1'b0, 4'b0000, 8'h00, 8'h00);
    run(1, 5);
    check_eq("single_grants", grant_log.size(), 1);

    // Tie after reset with both VALIDs held: grants alternate starting with requester 0
    do_reset(1);
    rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b1;
    set_req(1, 0, 1'b1, 4'b1111, 8'h55, 8'hCC);
    set_req(1, 1, 1'b1, 4'b1100, 8'h55, 8'h99);
    run(1, 16);
    check_eq("tie_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq($sformatf("tie_grant%0d", i), grant_log[i], i % 2);
    set_req(1, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    run(1, 2);

    // Backpressure on requester 1 while requester 0 waits
    do_reset(1);
    rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b0;
    set_req(1, 1, 1'b1, 4'h3, 8'h81, 8'h7E);
    cycle(1);
    set_req(1, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    run(1, 2);
    set_req(1, 0, 1'b1, 4'h1, 8'h10, 8'h20);
    run(1, 5);
    check_eq("bp_no_accept", grant_log.size(), 1);
    rsp1_ready[1] = 1'b1;
    cycle(1);
    cycle(1);
    set_req(1, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    run(1, 4);
    check_eq("bp_grants", grant_log.size(), 2);

    // Reset one cycle after acceptance drops the operation
    do_reset(1);
    rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b1;
    set_req(1, 0, 1'b1, 4'h6, 8'h3C, 8'hC3);
    cycle(1);
    set_req(1, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_eq("rst_no_rsp", {rsp1_valid[1], rsp0_valid[1], busy[1]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(1);
    rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b1;
    set_req(1, 0, 1'b1, 4'h2, 8'h0F, 8'hF0);
    set_req(1, 1, 1'b1, 4'h5, 8'hA5, 8'h5A);
    cycle(1);
    check_eq("tie_after_rst", (grant_log.size() == 1) ? grant_log[0] : 99, 0);
    set_req(1, 0, 1'b0, 4'h0, 8'h00, 8'h00);
    set_req(1, 1, 1'b0, 4'h0, 8'h00, 8'h00);
    run(1, 4);

    // Latency sweep over the three instances
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      rsp0_ready[k] = 1'b1; rsp1_ready[k] = 1'b1;
      set_req(k, 1, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      cycle(k);
      set_req(k, 1, 1'b0, 4'h0, 8'h00, 8'h00);
      run(k, lat_of(k) + 4);
      check_eq("lat_done", {m_busy, 8'(exp_q.size())}, 0);
    end

    // Opcode pass-through, all 16 codes
    do_reset(1);
    rsp0_ready[1] = 1'b1; rsp1_ready[1] = 1'b1;
    for (int op = 0; op < 16; op++) begin
      int r;
      r = int'($urandom_range(0, 1));
      set_req(1, r, 1'b1, 4'(op), 8'hFF, 8'hFF);
      cycle(1);
      set_req(1, r, 1'b0, 4'h0, 8'h00, 8'h00);
      check_eq($sformatf("opcode%0d", op), {alu_s2[1], alu_s1[1], alu_sel[1]}, op);
      run(1, 3);
    end

    // Randomized traffic on every instance
    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      for (int i = 0; i < 300; i++) begin
        set_req(k, 0, ($urandom_range(0, 1) == 1), 4'($urandom), 8'($urandom), 8'($urandom));
        set_req(k, 1, ($urandom_range(0, 1) == 1), 4'($urandom), 8'($urandom), 8'($urandom));
        rsp0_ready[k] = ($urandom_range(0, 3) != 0);
        rsp1_ready[k] = ($urandom_range(0, 3) != 0);
        cycle(k);
      end
      set_req(k, 0, 1'b0, 4'h0, 8'h00, 8'h00);
      set_req(k, 1, 1'b0, 4'h0, 8'h00, 8'h00);
      rsp0_ready[k] = 1'b1; rsp1_ready[k] = 1'b1;
      run(k, 12);
      check_eq("drain_empty", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
